// File: rtl/sysid_info_regs_pkg.sv
// sysid_info_pkg: register map offsets, CTRL bit positions, VERSION field layout
// and a byte-lane merge helper shared by the system-ID register block.
// No ports; pure compile-time definitions.
package sysid_info_pkg;

  // Word offsets of the register file
  localparam int unsigned SYSID_OFS     = 0;
  localparam int unsigned TIMESTAMP_OFS = 1;
  localparam int unsigned VERSION_OFS   = 2;
  localparam int unsigned CAPS_OFS      = 3;
  localparam int unsigned UPTIME_LO_OFS = 4;
  localparam int unsigned UPTIME_HI_OFS = 5;
  localparam int unsigned SCRATCH_OFS   = 6;
  localparam int unsigned CTRL_OFS      = 7;

  // CTRL register bits
  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  // VERSION word layout {major, minor, patch}
  localparam int unsigned VER_MAJOR_LSB = 24;
  localparam int unsigned VER_MAJOR_W   = 8;
  localparam int unsigned VER_MINOR_LSB = 16;
  localparam int unsigned VER_MINOR_W   = 8;
  localparam int unsigned VER_PATCH_LSB = 0;
  localparam int unsigned VER_PATCH_W   = 16;

  // Replace the byte lanes of old_v selected by be with those of new_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sysid_info_regs_if.sv
// Avalon-MM style slave bus for the system-ID register block.
// master drives address/read/write/writedata/byteenable; slave returns
// readdata/readdatavalid one cycle after a read (no waitrequest).
interface sysid_info_regs_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_info_regs_uptime_counter.sv
// sysid_uptime_counter: prescaler plus UPTIME_W-bit free-running uptime counter.
// Ports: clock, reset_n, i_clear (sync clear, beats tick), i_freeze (hold all),
//        o_tick (prescaler wrap this cycle), o_uptime (live count).
module sysid_uptime_counter
  import sysid_info_pkg::*;
#(
  parameter int UPTIME_W = 64,
  parameter int PRESCALE = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_clear,
  input  logic                i_freeze,
  output logic                o_tick,
  output logic [UPTIME_W-1:0] o_uptime
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     r_presc;
  logic [UPTIME_W-1:0] r_uptime;
  logic                w_tick;

  // With PRESCALE=1 the prescaler sits at 0 == PS_LAST, so every unfrozen cycle ticks.
  assign w_tick   = !i_freeze && (r_presc == PS_LAST);
  assign o_tick   = w_tick;
  assign o_uptime = r_uptime;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc  <= '0;
      r_uptime <= '0;
    end else if (i_clear) begin
      r_presc  <= '0;
      r_uptime <= '0;
    end else if (w_tick) begin
      r_presc  <= '0;
      r_uptime <= r_uptime + UPTIME_W'(1);
    end else if (!i_freeze) begin
      r_presc  <= r_presc + PS_W'(1);
    end
  end

endmodule

// File: rtl/sysid_info_regs.sv
// sysid_info_regs: system-ID register file (ID, timestamp, version, caps, uptime
// with coherent lo/hi snapshot, scratch, ctrl) on an Avalon-MM slave.
// Ports: clock, reset_n, s_bus (slave modport; 1-cycle registered read, no waitrequest).
module sysid_info_regs
  import sysid_info_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h0000001F,
  parameter logic [31:0] TIMESTAMP = 32'd1718188374,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter logic [31:0] CAPS      = 32'h0000_0001,
  parameter int          ADDR_W    = 4,
  parameter int          UPTIME_W  = 64,
  parameter int          PRESCALE  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  sysid_info_regs_if.slave  s_bus
);

  localparam int HI_W = UPTIME_W - 32;

  logic [UPTIME_W-1:0] w_uptime;
  logic                w_wr_ctrl;
  logic                w_wr_scratch;
  logic                w_clear;
  logic                w_rd_lo;
  logic [31:0]         w_rdata;

  logic                r_freeze;
  logic [31:0]         r_scratch;
  logic [HI_W-1:0]     r_hi_shadow;
  logic [31:0]         r_readdata;
  logic                r_readdatavalid;

  // CTRL only has meaningful bits in byte lane 0.
  assign w_wr_ctrl    = s_bus.write && (s_bus.address == ADDR_W'(CTRL_OFS)) && s_bus.byteenable[0];
  assign w_wr_scratch = s_bus.write && (s_bus.address == ADDR_W'(SCRATCH_OFS));
  assign w_clear      = w_wr_ctrl && s_bus.writedata[CTRL_CLEAR];
  assign w_rd_lo      = s_bus.read && (s_bus.address == ADDR_W'(UPTIME_LO_OFS));

  sysid_uptime_counter #(
    .UPTIME_W (UPTIME_W),
    .PRESCALE (PRESCALE)
  ) u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_clear),
    .i_freeze (r_freeze),
    .o_tick   (),
    .o_uptime (w_uptime)
  );

  // Read mux sees pre-edge state, so a read coincident with a write or a tick
  // returns the old value.
  always_comb begin
    w_rdata = '0;
    case (s_bus.address)
      ADDR_W'(SYSID_OFS):     w_rdata = SYSTEM_ID;
      ADDR_W'(TIMESTAMP_OFS): w_rdata = TIMESTAMP;
      ADDR_W'(VERSION_OFS):   w_rdata = VERSION;
      ADDR_W'(CAPS_OFS):      w_rdata = CAPS;
      ADDR_W'(UPTIME_LO_OFS): w_rdata = w_uptime[31:0];
      ADDR_W'(UPTIME_HI_OFS): w_rdata = 32'(r_hi_shadow);
      ADDR_W'(SCRATCH_OFS):   w_rdata = r_scratch;
      ADDR_W'(CTRL_OFS):      w_rdata[CTRL_FREEZE] = r_freeze;
      default:                w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_freeze        <= 1'b0;
      r_scratch       <= '0;
      r_hi_shadow     <= '0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= s_bus.read;
      if (s_bus.read) r_readdata <= w_rdata;
      // Snapshot the upper half together with the low read so LO-then-HI is coherent.
      if (w_rd_lo) r_hi_shadow <= w_uptime[UPTIME_W-1:32];
      if (w_wr_scratch) r_scratch <= be_merge(r_scratch, s_bus.writedata, s_bus.byteenable);
      if (w_wr_ctrl) r_freeze <= s_bus.writedata[CTRL_FREEZE];
    end
  end

  assign s_bus.readdata      = r_readdata;
  assign s_bus.readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench for sysid_info_regs: table vectors, random traffic against
// a cycle-count uptime model, and hand sequences for carry, clear and reset corners.
// All checks sampled on the falling clock edge.
module tb_sysid_info_regs;

  localparam int PRESCALE = 4;

  logic clock;
  logic reset_n;

  sysid_info_regs_if #(.ADDR_W(4)) bus ();

  sysid_info_regs #(
    .SYSTEM_ID (32'h0000001F),
    .TIMESTAMP (32'd1718188374),
    .VERSION   (32'h0001_0000),
    .CAPS      (32'h0000_0001),
    .ADDR_W    (4),
    .UPTIME_W  (64),
    .PRESCALE  (PRESCALE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .s_bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_err = 0;
  int n_chk = 0;

  // ---------------- behavioural model ----------------
  // uptime = base + (unfrozen cycles since clear) / PRESCALE
  bit [63:0] m_base, m_active;
  bit [31:0] m_scratch, m_shadow, m_rdata;
  bit        m_freeze, m_rvld;
  bit        ld_req = 1'b0;
  bit [63:0] ld_val = '0;

  function automatic bit [63:0] m_uptime();
    return m_base + m_active / PRESCALE;
  endfunction

  function automatic bit [31:0] m_hi();
    bit [63:0] u;
    u = m_uptime();
    return u[63:32];
  endfunction

  function automatic bit [31:0] m_read(input bit [3:0] a);
    bit [63:0] u;
    u = m_uptime();
    case (a)
      4'd0: return 32'h0000001F;
      4'd1: return 32'd1718188374;
      4'd2: return 32'h00010000;
      4'd3: return 32'h00000001;
      4'd4: return u[31:0];
      4'd5: return m_shadow;
      4'd6: return m_scratch;
      4'd7: return {30'd0, m_freeze, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
    bit [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_base <= '0; m_active <= '0; m_scratch <= '0; m_shadow <= '0;
      m_rdata <= '0; m_freeze <= 1'b0; m_rvld <= 1'b0;
    end else begin
      m_rvld <= bus.read;
      if (bus.read) begin
        m_rdata <= m_read(bus.address);
        if (bus.address == 4'd4) m_shadow <= m_hi();
      end
      if (bus.write && bus.address == 4'd6) m_scratch <= merge(m_scratch, bus.writedata, bus.byteenable);
      if (bus.write && bus.address == 4'd7 && bus.byteenable[0]) m_freeze <= bus.writedata[1];
      if (bus.write && bus.address == 4'd7 && bus.byteenable[0] && bus.writedata[0]) begin
        m_active <= '0;
        m_base   <= '0;
      end else begin
        if (!m_freeze) m_active <= m_active + 64'd1;
        if (ld_req) m_base <= ld_val;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input bit [31:0] got, input bit [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called on a falling edge; presents one read, checks valid and model data.
  task automatic bus_read(input bit [3:0] a, input string nm, output bit [31:0] d);
    bus.address = a; bus.read = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    check({nm, "_vld"}, {31'd0, bus.readdatavalid}, 32'd1);
    check({nm, "_model"}, bus.readdata, m_rdata);
    d = bus.readdata;
  endtask

  task automatic bus_write(input bit [3:0] a, input bit [31:0] wd, input bit [3:0] be);
    bus.address = a; bus.write = 1'b1; bus.writedata = wd; bus.byteenable = be;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  typedef struct {
    bit        rd;
    bit        wr;
    bit [3:0]  addr;
    bit [31:0] wd;
    bit [3:0]  be;
    bit [31:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    bit [31:0] d, v1, v2;
    bit        found;

    vt[0]  = '{1, 0, 4'd0,  32'h0,        4'h0, 32'h0000001F};
    vt[1]  = '{1, 0, 4'd1,  32'h0,        4'h0, 32'd1718188374};
    vt[2]  = '{1, 0, 4'd2,  32'h0,        4'h0, 32'h00010000};
    vt[3]  = '{1, 0, 4'd3,  32'h0,        4'h0, 32'h00000001};
    vt[4]  = '{1, 0, 4'd12, 32'h0,        4'h0, 32'h0};
    vt[5]  = '{0, 1, 4'd6,  32'hDEADBEEF, 4'h5, 32'h0};
    vt[6]  = '{1, 0, 4'd6,  32'h0,        4'h0, 32'h00AD00EF};
    vt[7]  = '{0, 1, 4'd0,  32'h00001234, 4'hF, 32'h0};
    vt[8]  = '{1, 0, 4'd0,  32'h0,        4'h0, 32'h0000001F};
    vt[9]  = '{1, 1, 4'd6,  32'h11223344, 4'hA, 32'h00AD00EF};
    vt[10] = '{1, 0, 4'd6,  32'h0,        4'h0, 32'h11AD33EF};
    vt[11] = '{0, 1, 4'd9,  32'hFFFFFFFF, 4'hF, 32'h0};
    vt[12] = '{1, 0, 4'd9,  32'h0,        4'h0, 32'h0};
    vt[13] = '{0, 1, 4'd7,  32'hFFFFFFFF, 4'hE, 32'h0};
    vt[14] = '{1, 0, 4'd7,  32'h0,        4'h0, 32'h0};
    vt[15] = '{1, 0, 4'd15, 32'h0,        4'h0, 32'h0};

    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0;
    reset_n = 1'b0;
    idle(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_vld", {31'd0, bus.readdatavalid}, 32'd0);
    reset_n = 1'b1;

    // Uptime after 40 cycles, freeze, resume
    idle(40);
    bus_read(4'd4, "up40", d);
    check("up40_abs", d, 32'd10);
    bus_write(4'd7, 32'h2, 4'hF);
    bus_read(4'd4, "frz_a", v1);
    idle(100);
    bus_read(4'd4, "frz_b", v2);
    check("frz_hold", v2, v1);
    bus_read(4'd7, "ctrl_frz", d);
    check("ctrl_frz_val", d, 32'h2);
    bus_write(4'd7, 32'h0, 4'hF);
    idle(20);
    bus_read(4'd4, "resume", d);
    check("resume_adv", {31'd0, d > v2}, 32'd1);

    // Table vectors
    for (int i = 0; i < 16; i++) begin
      bus.address = vt[i].addr; bus.read = vt[i].rd; bus.write = vt[i].wr;
      bus.writedata = vt[i].wd; bus.byteenable = vt[i].be;
      @(negedge clock);
      bus.read = 1'b0; bus.write = 1'b0;
      check($sformatf("vec%0d_vld", i), {31'd0, bus.readdatavalid}, {31'd0, vt[i].rd});
      if (vt[i].rd) check($sformatf("vec%0d_data", i), bus.readdata, vt[i].exp);
    end

    // readdata holds between reads
    bus_read(4'd1, "hold_rd", d);
    idle(2);
    check("hold_data", bus.readdata, 32'd1718188374);
    check("hold_vld", {31'd0, bus.readdatavalid}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit rd, wr;
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 3) == 0);
      bus.address = 4'($urandom_range(0, 15));
      bus.read = rd; bus.write = wr;
      bus.writedata = $urandom; bus.byteenable = 4'($urandom);
      @(negedge clock);
      bus.read = 1'b0; bus.write = 1'b0;
      check("rnd_vld", {31'd0, bus.readdatavalid}, {31'd0, rd});
      if (rd) check("rnd_data", bus.readdata, m_rdata);
    end

    // 32-bit carry with coherent snapshot: clear+freeze, preload, release freeze
    bus_write(4'd7, 32'h3, 4'hF);
    force dut.u_uptime.r_uptime = 64'h0000_0000_FFFF_FFFF;
    ld_val = 64'h0000_0000_FFFF_FFFF;
    ld_req = 1'b1;
    @(negedge clock);
    release dut.u_uptime.r_uptime;
    ld_req = 1'b0;
    bus_write(4'd7, 32'h0, 4'hF);
    idle(PRESCALE - 1);
    bus_read(4'd4, "carry_lo0", d);
    check("carry_lo0_abs", d, 32'hFFFFFFFF);
    bus_read(4'd5, "carry_hi0", d);
    check("carry_hi0_abs", d, 32'h0);
    bus_read(4'd4, "carry_lo1", d);
    check("carry_lo1_abs", d, 32'h0);
    bus_read(4'd5, "carry_hi1", d);
    check("carry_hi1_abs", d, 32'h1);

    // CLEAR on a tick cycle; shadow untouched
    found = 1'b0;
    for (int i = 0; i < 2 * PRESCALE; i++) begin
      if (!m_freeze && (m_active % PRESCALE) == PRESCALE - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!found) begin
      n_chk++; n_err++;
      $display("FAIL tick_align: got no tick slot expected one within %0d cycles", 2 * PRESCALE);
    end
    bus_write(4'd7, 32'h1, 4'hF);
    bus_read(4'd5, "clr_shadow", d);
    check("clr_shadow_abs", d, 32'h1);
    bus_read(4'd4, "clr_lo", d);
    check("clr_lo_abs", d, 32'h0);
    bus_read(4'd7, "clr_ctrl", d);
    check("clr_ctrl_abs", d, 32'h0);

    // Reset in the middle of a read
    bus_write(4'd6, 32'hA5A5A5A5, 4'hF);
    idle(8);
    bus.address = 4'd6; bus.read = 1'b1;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, bus.readdatavalid}, 32'd0);
    check("mid_rst_data", bus.readdata, 32'h0);
    bus.read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_vld", {31'd0, bus.readdatavalid}, 32'd0);
    bus_read(4'd6, "post_scratch", d);
    check("post_scratch_abs", d, 32'h0);
    bus_read(4'd4, "post_lo", d);
    check("post_lo_abs", d, 32'h0);
    bus_read(4'd5, "post_hi", d);
    check("post_hi_abs", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
Parametrised successor to the two-word system-ID slave. It is an Avalon-MM slave exposing a small register file: system ID, build timestamp, version, capability word, a free-running 64-bit uptime counter with coherent hi/lo snapshot, a scratch register and a control register. It sits on the CPU data master's control bus, where boot software uses it to identify and sanity-check the hardware image.

Parameters:
SYSTEM_ID, 32'h0000001F, value returned at word 0.
TIMESTAMP, 32'd1718188374, build time (Unix seconds) returned at word 1.
VERSION, 32'h0001_0000, format {major[31:24], minor[23:16], patch[15:0]}, returned at word 2.
CAPS, 32'h0000_0001, capability word, e.g. [7:0] CPU count; returned at word 3.
ADDR_W, 4, word-address width, minimum 3; words 8 .. 2^ADDR_W-1 read 0.
UPTIME_W, 64, uptime counter width, range 33..64; bits above UPTIME_W read 0.
PRESCALE, 1, number of clock cycles per uptime tick, minimum 1.

Ports:
clock  in  1  system clock; the only clock.
reset_n  in  1  asynchronous, active-low reset.
address  in  ADDR_W  word address.
read  in  1  read strobe, one cycle per access.
write  in  1  write strobe, one cycle per access.
writedata  in  32  write data.
byteenable  in  4  byte lanes for writes.
readdata  out  32  registered read data.
readdatavalid  out  1  high exactly one cycle after an accepted read.

Behaviour:
- No waitrequest; every access is accepted in the cycle it is presented. Fixed read latency of 1: readdata and readdatavalid are registered. Between reads, readdata holds its last value.
- Reset (asynchronous assert, synchronous release) sets readdata=0, readdatavalid=0, uptime=0, prescaler=0, uptime_hi_shadow=0, scratch=0, ctrl.freeze=0.
- Register map (word address):
  - 0 SYSTEM_ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 VERSION (RO)
  - 3 CAPS (RO)
  - 4 UPTIME_LO (RO): returns uptime[31:0] and, in the same cycle, latches uptime[UPTIME_W-1:32] into uptime_hi_shadow.
  - 5 UPTIME_HI (RO): returns the shadow, not the live value.
  - 6 SCRATCH (RW): byte-enabled.
  - 7 CTRL (RW): bit0 CLEAR is write-1 pulse, self-clearing, and reads 0. bit1 FREEZE is a level. All other bits read 0.
  - Any other address reads 0; writes to it are ignored.
- Writes to RO words are ignored with no side effects.
- Uptime:
  - The prescaler counts 0..PRESCALE-1 while FREEZE=0. A tick occurs when it wraps.
  - Each tick increments uptime, which wraps modulo 2^UPTIME_W without saturating.
  - While FREEZE=1, both the prescaler and uptime hold.
- Simultaneous events:
  - CLEAR write and tick in the same cycle: CLEAR wins. Next cycle uptime=0 and prescaler=0.
  - UPTIME_LO read and tick in the same cycle: readdata and the shadow both capture the pre-increment value, so the lo/hi pair stays coherent across a 32-bit carry.
  - read and write asserted together: the write takes effect and readdata returns the pre-write value.
  - CLEAR does not modify uptime_hi_shadow.
- Reset asserted mid-read: readdatavalid drops immediately and no valid is issued for that read.

Decomposition:
- Package sysid_info_pkg holds the word offsets (SYSID_OFS=0 .. CTRL_OFS=7), the CTRL bit indices (CTRL_CLEAR=0, CTRL_FREEZE=1) and the VERSION field positions.
- One sub-module, sysid_uptime_counter. It contains the prescaler, the UPTIME_W counter with clear/freeze, and the tick output.

Test Plan:
1. Reset release, then read words 0..3 -> 0x1F, 1718188374, 0x00010000, 0x00000001; readdatavalid high exactly one cycle after each read. Read word 12 -> 0.
2. PRESCALE=4, wait 40 cycles after reset, read UPTIME_LO -> 10 (±1 for read-path alignment, checked against the model). Set FREEZE, wait 100 cycles -> value unchanged. Clear FREEZE -> counting resumes.
3. Force uptime to 0x0000_0000_FFFF_FFFF one cycle before a tick. Read LO on the tick cycle -> LO=0xFFFFFFFF, then HI=0x0. Read LO again -> 0x0, then HI=0x1.
4. Write SCRATCH 0xDEADBEEF with byteenable=4'b0101 over 0x0 -> reads 0x00AD00EF. Write SYSTEM_ID 0x1234 -> still reads 0x1F.
5. Write CTRL=0x1 on the same cycle as a tick -> uptime reads 0 next; CTRL reads 0x0; the shadow is unchanged.
6. Assert reset_n low for 1 cycle in the middle of a read -> no readdatavalid; readdata=0; scratch=0; uptime=0.
